// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings and defaults for the bit-serial adder
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_fa_cell.sv
// rtl/serial_fa_cell.sv - combinational 1-bit full adder cell
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    // One full-adder bit: sum and carry from two operand bits plus carry-in
    always_comb begin
        sum   = a ^ b ^ cin;
        carry = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_OVF_EN adds the ovf output
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_sum, fa_carry;
    logic             accept;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    serial_fa_cell u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Start is only honoured when no operation is in flight
    always_comb begin
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    // Next-state: capture operands on accept, shift one bit per RUN cycle
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            state_d = S_RUN;
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                    a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_d = fa_carry;
                    if (cnt_q == CNT_LAST) begin
                        // MSB just processed: carry into it is still in carry_q
                        cout_d  = fa_carry;
                        state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_d   = carry_q ^ fa_carry;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_IDLE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Outputs are decoded straight from registered state
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule
